// File: rtl/btn_event_ctrl.sv
// Pushbutton front-end: shared sample tick, per-channel synchroniser and debouncer,
// pending-event capture and a fixed-priority valid/ack presenter. Define HOLD_REPEAT_EN for hold-to-repeat.
module btn_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_CNT   = 4,
  parameter int REPEAT_TICKS = 50,
  localparam int ID_W        = $clog2(N_BTN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic             tick,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  input  logic             evt_ack,
  output logic             overrun
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
  localparam logic [3:0]    STABLE_LAST = 4'(STABLE_CNT - 1);

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state;
  logic [TW-1:0]    div_cnt;
  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [3:0]       db_cnt     [N_BTN];
  logic [3:0]       db_cnt_nxt [N_BTN];
  logic [N_BTN-1:0] level_nxt;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] rep_hit;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] clr;
  logic [ID_W-1:0]  pick_idx;

  // Sample-tick divider: tick is high for the cycle after the counter hits its last value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == TICK_LAST);
      div_cnt <= (div_cnt == TICK_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
    end
  end

  // Stable-count debounce; a level flips only after STABLE_CNT consecutive mismatching ticks.
  always_comb begin
    level_nxt = btn_level;
    for (int i = 0; i < N_BTN; i++) begin
      db_cnt_nxt[i] = db_cnt[i];
      if (!tick) begin
        db_cnt_nxt[i] = db_cnt[i];
      end else if (sync_b[i] == btn_level[i]) begin
        db_cnt_nxt[i] = 4'd0;
      end else if (db_cnt[i] == STABLE_LAST) begin
        level_nxt[i]  = ~btn_level[i];
        db_cnt_nxt[i] = 4'd0;
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + 4'd1;
      end
    end
    rise = level_nxt & ~btn_level;
  end

  // Debounced level and stable counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= 4'd0;
    end else begin
      btn_level <= level_nxt;
      for (int i = 0; i < N_BTN; i++) db_cnt[i] <= db_cnt_nxt[i];
    end
  end

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [RW-1:0] rep_cnt [N_BTN];

  // A held channel raises a repeat on every REPEAT_TICKS-th tick.
  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      rep_hit[i] = tick && btn_level[i] && (rep_cnt[i] == REP_LAST);
    end
  end

  // Repeat tick counters, held at zero while the button is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) rep_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (!btn_level[i]) begin
          rep_cnt[i] <= '0;
        end else if (tick) begin
          rep_cnt[i] <= rep_hit[i] ? '0 : rep_cnt[i] + 1'b1;
        end else begin
          rep_cnt[i] <= rep_cnt[i];
        end
      end
    end
  end
`else
  logic unused_repeat;
  assign rep_hit       = '0;
  assign unused_repeat = (REPEAT_TICKS > 0);
`endif

  // Lowest pending index wins; its bit is cleared as the FSM launches it.
  always_comb begin
    pick_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      pick_idx = pending[i] ? ID_W'(i) : pick_idx;
    end
    if (state == IDLE && pending != '0) begin
      clr = N_BTN'(1) << pick_idx;
    end else begin
      clr = '0;
    end
  end

  // Pending events (a new set beats a same-cycle clear) and the sticky lost-press flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr) | rise | rep_hit;
      if (|(rise & pending & ~clr)) begin
        overrun <= 1'b1;
      end else begin
        overrun <= overrun;
      end
    end
  end

  // Presenter FSM: holds one event stable until the consumer acks it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pending != '0) begin
            evt_valid <= 1'b1;
            evt_id    <= pick_idx;
            state     <= PRESENT;
          end else begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        PRESENT: begin
          if (evt_ack) begin
            evt_valid <= 1'b0;
            state     <= IDLE;
          end else begin
            evt_valid <= 1'b1;
            state     <= PRESENT;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Scoreboard bench for btn_event_ctrl: stimulus pushes expected event ids, a negedge monitor pops on each handshake.
module tb_btn_event_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn_raw = 4'd0;
  logic       evt_ack = 1'b0;
  logic [3:0] btn_level;
  logic       tick;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       overrun;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int hs_count = 0;
  int cyc = 0;
  int last_hs = 0;
  int prev_hs = 0;
  int n, bad, tcount, last, hs0, vseen, exp_hs;

  btn_event_ctrl #(.N_BTN(4), .TICK_DIV(4), .STABLE_CNT(3), .REPEAT_TICKS(5)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .btn_level(btn_level), .tick(tick),
    .evt_valid(evt_valid), .evt_id(evt_id), .evt_ack(evt_ack), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input string name, input int ch, input logic val, output int cnt);
    cnt = 0;
    while (btn_level[ch] !== val && cnt < 40) begin
      step();
      cnt++;
    end
    check(name, int'(btn_level[ch]), int'(val));
  endtask

  // Monitor: every accepted handshake must match the next expected id.
  always @(negedge clk) begin : mon
    int e;
    cyc++;
    if (!rst && evt_valid && evt_ack) begin
      hs_count++;
      prev_hs = last_hs;
      last_hs = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event actual=%0d required=none", evt_id);
      end else begin
        e = exp_q.pop_front();
        check("evt_id", int'(evt_id), e);
      end
    end
  end

  initial begin
    // Reset and idle tick pattern
    repeat (3) step();
    check("rst_level", int'(btn_level), 0);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_overrun", int'(overrun), 0);
    check("rst_tick", int'(tick), 0);
    rst = 1'b0;
    tcount = 0; bad = 0; last = -1; vseen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (tick) begin
        if (last >= 0 && i - last != 4) bad++;
        last = i;
        tcount++;
      end
      if (btn_level != 4'd0 || evt_valid || overrun) vseen++;
    end
    check("tick_count", tcount, 10);
    check("tick_period", bad, 0);
    check("idle_outputs", vseen, 0);

    // Single press on channel 2, held ack low
    btn_raw[2] = 1'b1;
    wait_level("press2_level", 2, 1'b1, n);
    check("press2_latency_ok", int'(n <= 14), 1);
    exp_q.push_back(2);
    step();
    check("press2_valid", int'(evt_valid), 1);
    check("press2_id", int'(evt_id), 2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (!(evt_valid && evt_id == 2'd2)) bad++;
    end
    check("press2_stable", bad, 0);
    evt_ack = 1'b1;
    step();
    evt_ack = 1'b0;
    check("press2_drop", int'(evt_valid), 0);
    check("press2_popped", exp_q.size(), 0);
    btn_raw[2] = 1'b0;
    wait_level("rel2_level", 2, 1'b0, n);

    // Short glitch on channel 1 must be filtered
    hs0 = hs_count; bad = 0;
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 37; i++) begin
      if (i == 7) btn_raw[1] = 1'b0;
      step();
      if (btn_level[1] || evt_valid) bad++;
    end
    check("glitch_filtered", bad, 0);
    check("glitch_no_event", hs_count - hs0, 0);

    // Simultaneous presses on 3 and 0, ack tied high
    evt_ack = 1'b1;
    hs0 = hs_count;
    exp_q.push_back(0);
    exp_q.push_back(3);
    btn_raw = 4'b1001;
    n = 0;
    while (hs_count - hs0 < 2 && n < 60) begin
      step();
      n++;
    end
    check("simul_events", hs_count - hs0, 2);
    check("simul_gap", last_hs - prev_hs, 2);
    btn_raw = 4'b0000;
    repeat (20) step();
    check("simul_no_extra", hs_count - hs0, 2);
    check("simul_queue", exp_q.size(), 0);
    evt_ack = 1'b0;

    // Overrun: re-press channel 1 twice while its event is held
    hs0 = hs_count;
    btn_raw[1] = 1'b1;
    wait_level("ovr_p1", 1, 1'b1, n);
    exp_q.push_back(1);
    step();
    check("ovr_valid", int'(evt_valid), 1);
    check("ovr_id", int'(evt_id), 1);
    btn_raw[1] = 1'b0;
    wait_level("ovr_r1", 1, 1'b0, n);
    btn_raw[1] = 1'b1;
    wait_level("ovr_p2", 1, 1'b1, n);
    check("ovr_not_yet", int'(overrun), 0);
    exp_q.push_back(1);
    btn_raw[1] = 1'b0;
    wait_level("ovr_r2", 1, 1'b0, n);
    btn_raw[1] = 1'b1;
    wait_level("ovr_p3", 1, 1'b1, n);
    step();
    check("ovr_set", int'(overrun), 1);
    repeat (10) step();
    check("ovr_sticky", int'(overrun), 1);
    check("ovr_hold_valid", int'(evt_valid), 1);
    btn_raw[1] = 1'b0;
    wait_level("ovr_r3", 1, 1'b0, n);
    evt_ack = 1'b1;
    repeat (20) step();
    check("ovr_events", hs_count - hs0, 2);
    check("ovr_queue", exp_q.size(), 0);
    check("ovr_after_ack", int'(overrun), 1);
    evt_ack = 1'b0;

    // Reset in mid-handshake with another event still pending
    hs0 = hs_count;
    btn_raw = 4'b0101;
    wait_level("rst_p", 0, 1'b1, n);
    exp_q.push_back(0);
    exp_q.push_back(2);
    step();
    check("rst_mid_valid", int'(evt_valid), 1);
    check("rst_mid_id", int'(evt_id), 0);
    rst = 1'b1;
    #1;
    check("rst_async_valid", int'(evt_valid), 0);
    check("rst_async_id", int'(evt_id), 0);
    check("rst_async_level", int'(btn_level), 0);
    check("rst_async_overrun", int'(overrun), 0);
    exp_q.delete();
    btn_raw = 4'b0000;
    repeat (3) step();
    rst = 1'b0;
    evt_ack = 1'b1;
    vseen = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (evt_valid) vseen++;
    end
    check("rst_no_replay", vseen, 0);
    check("rst_no_hs", hs_count - hs0, 0);

    // Long hold on channel 0 (auto-repeat only when the feature is built in)
    hs0 = hs_count;
    btn_raw[0] = 1'b1;
    exp_q.push_back(0);
`ifdef HOLD_REPEAT_EN
    exp_hs = 7;
    for (int i = 0; i < 6; i++) exp_q.push_back(0);
`else
    exp_hs = 1;
`endif
    wait_level("hold_p", 0, 1'b1, n);
    tcount = 0; n = 0;
    while (tcount < 30 && n < 400) begin
      step();
      n++;
      if (tick) tcount++;
    end
    check("hold_ticks", tcount, 30);
    btn_raw[0] = 1'b0;
    wait_level("hold_r", 0, 1'b0, n);
    repeat (20) step();
    check("hold_events", hs_count - hs0, exp_hs);
    check("hold_queue", exp_q.size(), 0);
    check("hold_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_ctrl.md
Name: btn_event_ctrl

Overview:
- Front-end controller for all player pushbuttons (spin, bet-up, bet-down, cash-out) on the slot machine.
- Generates one shared debounce sample tick and runs a per-channel synchroniser and stable-count debouncer from it.
- Converts debounced presses into queued events and presents them one at a time to the game FSM over a valid/ack handshake, using fixed-priority arbitration.

Parameters:
- N_BTN, 4, number of button channels (2..8).
- TICK_DIV, 100000, clk cycles per debounce sample tick.
- STABLE_CNT, 4, consecutive ticks a new level must persist before it is accepted (1..15).
- REPEAT_TICKS, 50, ticks between auto-repeat events (used only with the optional feature).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- btn_raw, input, N_BTN, raw asynchronous button inputs, active-high.
- btn_level, output, N_BTN, debounced button levels.
- tick, output, 1, one-cycle debounce sample strobe.
- evt_valid, output, 1, event presented.
- evt_id, output, clog2(N_BTN), index of presented button.
- evt_ack, input, 1, consumer accepts event.
- overrun, output, 1, sticky flag: a press was lost.

Behaviour:
- Reset (asynchronous, active-high): tick counter=0, tick=0, both synchroniser flops=0, btn_level=0, stable counters=0, pending=0, evt_valid=0, evt_id=0, overrun=0, FSM=IDLE.
- Reset asserted mid-handshake drops the presented event and all pending events. No event is replayed after reset.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps to 0.
  - tick=1 for exactly the cycle after the counter equals TICK_DIV-1. Period is exactly TICK_DIV cycles.
- Synchroniser: two flops per channel. sync[i] lags btn_raw[i] by 2 clk.
- Debounce, evaluated on tick cycles only:
  - If sync[i]!=btn_level[i]: cnt[i]++. When cnt[i] would reach STABLE_CNT, toggle btn_level[i] and clear cnt[i].
  - If sync[i]==btn_level[i]: clear cnt[i].
  - A single mismatching sample shorter than STABLE_CNT ticks never changes btn_level.
- Press detect:
  - A btn_level[i] 0->1 transition sets pending[i] in the same cycle the level updates.
  - Release (1->0) produces no event.
- Overrun: a press on channel i while pending[i]=1 sets overrun (sticky until rst). pending[i] stays set.
- Arbiter FSM:
  - IDLE: if pending!=0, select the lowest set index k. Next cycle: evt_valid=1, evt_id=k, pending[k] cleared, go to PRESENT.
  - PRESENT: evt_valid and evt_id are held stable until evt_ack=1. On the cycle with evt_valid&evt_ack, evt_valid goes 0 next cycle and the FSM returns to IDLE.
  - Minimum spacing between events is therefore 1 idle cycle. Maximum throughput is 1 event per 2 clk when the consumer acks immediately.
  - evt_ack while evt_valid=0 is ignored.
- Simultaneous events:
  - Set and clear of pending[k] in the same cycle: set wins, so pending[k] remains 1.
  - Multiple channels pressed on the same tick: all pending bits are set; events are served in index order.
- Latency: a clean raw edge reaches btn_level within 2 clk + STABLE_CNT*TICK_DIV clk. evt_valid follows the level edge by 1 clk when the FSM is IDLE.

Optional Feature:
- Macro HOLD_REPEAT_EN.
- Defined: a per-channel repeat counter counts ticks while btn_level[i]=1.
  - After REPEAT_TICKS ticks it sets pending[i] and restarts; this repeats every REPEAT_TICKS ticks for as long as the button is held.
  - The counter clears on release or rst.
  - A repeat that finds pending[i] already set is dropped silently and does not set overrun.
- Not defined: repeat logic is absent. Only 0->1 level transitions generate events.

Test Plan (TICK_DIV=4, STABLE_CNT=3, REPEAT_TICKS=5, N_BTN=4):
- Reset then idle 40 clk -> tick pulses every 4 clk; btn_level=0, evt_valid=0, overrun=0.
- btn_raw[2] 0->1 held -> btn_level[2]=1 within 2+12 clk; next cycle evt_valid=1, evt_id=2. Hold evt_ack=0 for 10 clk -> outputs stable. Pulse ack -> evt_valid=0 next clk.
- btn_raw[1] glitch high for 7 clk (fewer than 3 ticks) -> btn_level[1] stays 0; no event.
- btn_raw[3] and btn_raw[0] rise on the same cycle, ack tied to 1 -> events id=0 then id=3 with 1 idle cycle between; pending=0 afterwards.
- Hold evt_ack=0 with event 1 presented; press, release and re-press btn 1 twice -> overrun=1 and stays 1; after acking, exactly one further id=1 event appears.
- Assert rst while evt_valid=1 with pending bits set -> all outputs 0 immediately. After rst release, no events appear without a new press.
- HOLD_REPEAT_EN defined, hold btn 0 for 30 ticks with ack tied high -> first event at the press, then one event every 5 ticks; overrun stays 0. Undefined build -> exactly 1 event.
